// File: rtl/byte_mem_arbiter_if.sv
// Request/response and byte-memory signals shared by the fetch path, the
// load/store path, the arbiter and the byte-wide memory.
interface byte_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;

  // Requesters and memory together form the master side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, busy, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, busy, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/byte_mem_arbiter.sv
// Round-robin arbiter sharing one big-endian byte memory port between fetch
// and load/store; each grant runs four byte beats and then acks the owner.
module byte_mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  byte_mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SHD_W  = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                owner_q, owner_d;   // 1 = load/store path
  logic                last_q, last_d;     // 1 = load/store path granted last
  logic                we_q, we_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [SHD_W-1:0]    shadow_q, shadow_d; // lanes 0..2; lane 3 comes straight off mem_rdata
  logic                gnt_d;

  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [WORD_W-1:0]   i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  // Next-state and next-output logic; memory outputs are precomputed one beat ahead.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    shadow_d    = shadow_q;
    gnt_d       = 1'b0;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On a conflict the path that was not granted last wins.
          gnt_d       = bus.d_req && (!bus.i_req || !last_q);
          owner_d     = gnt_d;
          last_d      = gnt_d;
          base_d      = gnt_d ? bus.d_addr : bus.i_addr;
          we_d        = gnt_d && bus.d_we;
          wdata_d     = bus.d_wdata;
          cnt_d       = '0;
          state_d     = ST_BEAT;
          mem_addr_d  = base_d;
          mem_we_d    = we_d;
          mem_wdata_d = wdata_d[31:24];
        end
      end
      ST_BEAT: begin
        unique case (cnt_q)
          2'd0:    shadow_d[23:16] = bus.mem_rdata;
          2'd1:    shadow_d[15:8]  = bus.mem_rdata;
          2'd2:    shadow_d[7:0]   = bus.mem_rdata;
          default: shadow_d        = shadow_q;
        endcase
        if (cnt_q == CNT_W'(3)) begin
          state_d = ST_DONE;
          i_ack_d = !owner_q;
          d_ack_d = owner_q;
          if (!we_q) begin
            if (owner_q) d_rdata_d = {shadow_q, bus.mem_rdata};
            else         i_rdata_d = {shadow_q, bus.mem_rdata};
          end
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          mem_addr_d = base_q + ADDR_W'(cnt_d);
          mem_we_d   = we_q;
          unique case (cnt_d)
            2'd1:    mem_wdata_d = wdata_q[23:16];
            2'd2:    mem_wdata_d = wdata_q[15:8];
            default: mem_wdata_d = wdata_q[7:0];
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      shadow_q    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Bench for byte_mem_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_byte_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_BEAT = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  byte_mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Byte memory (256 bytes, aliased on the low address byte) with a preload port.
  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  // Transaction model: a grant expands into four beat records and one done record.
  typedef struct packed {
    logic [1:0]  kind;
    logic        we;
    logic        is_d;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [31:0] word;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  logic [7:0]  exp_mem [256];
  logic [31:0] e_irdata, e_drdata;
  bit          e_last_d;

  task automatic grant();
    rec_t r;
    bit d;
    logic [31:0] base, word;
    d    = bus.d_req && (!bus.i_req || !e_last_d);
    e_last_d = d;
    base = d ? bus.d_addr : bus.i_addr;
    for (int k = 0; k < 4; k++) word[31 - 8*k -: 8] = exp_mem[8'(base + 32'(k))];
    if (d && bus.d_we) word = bus.d_wdata;
    for (int k = 0; k < 4; k++) begin
      r.kind = K_BEAT; r.we = d && bus.d_we; r.is_d = d;
      r.addr = base + 32'(k); r.wdata = word[31 - 8*k -: 8]; r.word = word;
      q.push_back(r);
    end
    r.kind = K_DONE; r.addr = '0; r.wdata = '0;
    q.push_back(r);
  endtask

  initial begin
    bit rz;
    cur = '0; e_irdata = '0; e_drdata = '0; e_last_d = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (pl_en) exp_mem[pl_addr] = pl_data;
      if (!rst_n) begin
        q.delete(); cur = '0; e_irdata = '0; e_drdata = '0; e_last_d = 1'b1;
      end else begin
        if (cur.kind == K_BEAT && cur.we) exp_mem[cur.addr[7:0]] = cur.wdata;
        if (cur.kind == K_IDLE && (bus.i_req || bus.d_req)) grant();
        cur = (q.size() > 0) ? q.pop_front() : '0;
        if (cur.kind == K_DONE && !cur.we) begin
          if (cur.is_d) e_drdata = cur.word;
          else          e_irdata = cur.word;
        end
      end
      #1;
      rz = !rst_n;
      check("busy",    32'(bus.busy),   32'(!rz && cur.kind != K_IDLE));
      check("mem_we",  32'(bus.mem_we), 32'(!rz && cur.kind == K_BEAT && cur.we));
      check("i_ack",   32'(bus.i_ack),  32'(!rz && cur.kind == K_DONE && !cur.is_d));
      check("d_ack",   32'(bus.d_ack),  32'(!rz && cur.kind == K_DONE && cur.is_d));
      check("i_rdata", bus.i_rdata, e_irdata);
      check("d_rdata", bus.d_rdata, e_drdata);
      if (rz || cur.kind == K_BEAT) check("mem_addr", bus.mem_addr, rz ? 32'd0 : cur.addr);
      if (rz || (cur.kind == K_BEAT && cur.we))
        check("mem_wdata", 32'(bus.mem_wdata), rz ? 32'd0 : 32'(cur.wdata));
    end
  end

  // Directed stimulus; run() records ack cycles and beat addresses relative to its start.
  int          ia[$], da[$];
  logic [31:0] addrs[$];

  task automatic run(input int ncyc);
    ia.delete(); da.delete(); addrs.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #2;
      if (bus.i_ack) ia.push_back(c);
      if (bus.d_ack) da.push_back(c);
      if (bus.busy && !bus.i_ack && !bus.d_ack) addrs.push_back(bus.mem_addr);
    end
  endtask

  function automatic logic [31:0] at_a(input int i);
    return (i < addrs.size()) ? addrs[i] : 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] at_i(input int i);
    return (i < ia.size()) ? 32'(ia[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] at_d(input int i);
    return (i < da.size()) ? 32'(da[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
  endfunction

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    run(3);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_mem_we",  32'(bus.mem_we), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    preload(8'h10, 8'h12); preload(8'h11, 8'h34); preload(8'h12, 8'h56); preload(8'h13, 8'h78);
    preload(8'hFE, 8'hC1); preload(8'hFF, 8'hC2); preload(8'h00, 8'hC3); preload(8'h01, 8'hC4);
    for (int i = 3; i <= 10; i++) preload(8'(i), 8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) preload(8'(8'h40 + i), 8'hAA);

    // Fetch read
    @(negedge clk); bus.i_addr = 32'h10; bus.i_req = 1'b1;
    run(5);
    @(negedge clk); bus.i_req = 1'b0;
    check("t1_ack_cyc", at_i(0), 32'd5);
    check("t1_addr0", at_a(0), 32'h10);
    check("t1_addr3", at_a(3), 32'h13);
    check("t1_rdata", bus.i_rdata, 32'h1234_5678);
    run(2);

    // Store then load
    @(negedge clk); bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF; bus.d_req = 1'b1;
    run(5);
    @(negedge clk); bus.d_req = 1'b0;
    check("t2_st_ack_cyc", at_d(0), 32'd5);
    check("t2_st_rdata", bus.d_rdata, 32'd0);
    run(2);
    check("t2_mem", mem_word(8'h20), 32'hDEAD_BEEF);
    @(negedge clk); bus.d_we = 1'b0; bus.d_req = 1'b1;
    run(5);
    @(negedge clk); bus.d_req = 1'b0;
    check("t2_ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    run(2);

    // Wrapping load
    @(negedge clk); bus.d_addr = 32'hFFFF_FFFE; bus.d_req = 1'b1;
    run(5);
    @(negedge clk); bus.d_req = 1'b0;
    check("t4_addr0", at_a(0), 32'hFFFF_FFFE);
    check("t4_addr1", at_a(1), 32'hFFFF_FFFF);
    check("t4_addr2", at_a(2), 32'h0000_0000);
    check("t4_addr3", at_a(3), 32'h0000_0001);
    check("t4_rdata", bus.d_rdata, 32'hC1C2_C3C4);
    run(2);

    // Unaligned back-to-back fetches
    @(negedge clk); bus.i_addr = 32'h03; bus.i_req = 1'b1;
    run(5);
    check("t6_ack1_cyc", at_i(0), 32'd5);
    check("t6_rdata1", bus.i_rdata, 32'hA3A4_A5A6);
    @(negedge clk); bus.i_addr = 32'h07;
    run(6);
    @(negedge clk); bus.i_req = 1'b0;
    check("t6_ack2_cyc", at_i(0), 32'd6);
    check("t6_ack2_cnt", 32'(ia.size()), 32'd1);
    check("t6_rdata2", bus.i_rdata, 32'hA7A8_A9AA);
    run(2);

    // Conflict from reset: fetch, data, fetch
    @(negedge clk); rst_n = 1'b0;
    bus.i_addr = 32'h10; bus.d_addr = 32'h20; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    run(2);
    @(negedge clk); rst_n = 1'b1;
    run(17);
    @(negedge clk); bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("t3_i_ack0", at_i(0), 32'd5);
    check("t3_d_ack0", at_d(0), 32'd11);
    check("t3_i_ack1", at_i(1), 32'd17);
    check("t3_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    run(2);

    // Reset during beat 2 of a store
    @(negedge clk); bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1122_3344; bus.d_req = 1'b1;
    run(3);
    @(negedge clk);
    check("t5_we_beat2", 32'(bus.mem_we), 32'd1);
    check("t5_addr_beat2", bus.mem_addr, 32'h42);
    rst_n = 1'b0; #1;
    check("t5_we_async", 32'(bus.mem_we), 32'd0);
    check("t5_busy_async", 32'(bus.busy), 32'd0);
    check("t5_addr_async", bus.mem_addr, 32'd0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    run(2);
    @(negedge clk); rst_n = 1'b1;
    run(1);
    check("t5_mem", mem_word(8'h40), 32'h1122_AAAA);
    @(negedge clk); bus.i_addr = 32'h10; bus.i_req = 1'b1;
    run(5);
    @(negedge clk); bus.i_req = 1'b0;
    check("t5_fetch_cyc", at_i(0), 32'd5);
    check("t5_fetch_rdata", bus.i_rdata, 32'h1234_5678);
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
